pg_generate_stage: RTL and testbench

Registered bit-level generate/propagate pre-processing stage of the prefix adder. Accepts operand pairs over a valid/ready handshake. Computes per-bit generate (a AND b) and propagate (a XOR b) vectors and presents them, registered, to the prefix-node tree directly downstream. A two-entry skid buffer keeps full throughput while cutting the ready path combinationally between the tree and the operand source.

---
 rtl/pg_stage_pkg.sv | 21 ++
 rtl/pg_cell.sv | 25 ++
 rtl/pg_generate_stage.sv | 191 +++++++++++++++++++
 tb/tb_pg_generate_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pg_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pg_stage_pkg
//  Description : Shared constants and state encoding for the registered
//                generate/propagate stage of the prefix adder.
//  Revision    : 1.0  initial release
// ============================================================================
package pg_stage_pkg;

   // Operand width used when the instantiating level does not override it
   localparam int DEFAULT_WIDTH = 16;

   // Occupancy of the two-entry skid buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // main register invalid
      ONE   = 2'd1,   // main valid, skid empty
      FULL  = 2'd2    // main and skid both valid
   } pg_state_t;

endpackage : pg_stage_pkg
`default_nettype wire

// File: rtl/pg_cell.sv
`default_nettype none
// ============================================================================
//  Module      : pg_cell
//  Description : One-bit generate/propagate cell. With cin_en_bit set, the
//                carry-in is folded into the generate term so the bit behaves
//                as if the carry were generated locally.
//  Revision    : 1.0  initial release
// ============================================================================
module pg_cell (
   input  logic a,
   input  logic b,
   input  logic cin_en_bit,
   input  logic cin,
   output logic gen,
   output logic prop
);

   // Propagate is the half-sum; generate optionally absorbs the carry-in
   always_comb begin
      prop = a ^ b;
      gen  = (a & b) | (cin_en_bit & (a ^ b) & cin);
   end

endmodule : pg_cell
`default_nettype wire

// File: rtl/pg_generate_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pg_generate_stage
//  Description : Registered bit-level generate/propagate stage. Operands
//                arrive over valid/ready; gen/prop vectors leave through a
//                main output register backed by one skid register so that
//                in_ready is a pure register output (no path from out_ready).
//                Optional carry-in support: define PG_STAGE_CARRY_IN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pg_generate_stage
   import pg_stage_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef PG_STAGE_CARRY_IN_EN
   input  logic             in_cin,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gen,
`ifdef PG_STAGE_CARRY_IN_EN
   output logic             out_cin,
`endif
   output logic [WIDTH-1:0] out_prop
);

   pg_state_t        state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] main_gen_q, main_gen_d;
   logic [WIDTH-1:0] main_prop_q, main_prop_d;
   logic [WIDTH-1:0] skid_gen_q, skid_gen_d;
   logic [WIDTH-1:0] skid_prop_q, skid_prop_d;

   logic             in_fire;
   logic             out_fire;
   logic             load_main_in;    // main <= freshly computed pg
   logic             load_main_skid;  // main <= skid
   logic             load_skid_in;    // skid <= freshly computed pg
   logic             cin_in;
   logic [WIDTH-1:0] pg_gen;
   logic [WIDTH-1:0] pg_prop;

`ifdef PG_STAGE_CARRY_IN_EN
   assign cin_in = in_cin;
`else
   assign cin_in = 1'b0;
`endif

   // Bitwise generate/propagate; only bit 0 folds in the carry-in
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         pg_cell u_cell (
            .a          (in_a[i]),
            .b          (in_b[i]),
            .cin_en_bit ((i == 0) ? 1'b1 : 1'b0),
            .cin        (cin_in),
            .gen        (pg_gen[i]),
            .prop       (pg_prop[i])
         );
      end
   endgenerate

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Occupancy next-state and register load enables
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               state_d      = FULL;
               load_skid_in = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain side can move
            if (out_fire) begin
               state_d        = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Handshake flags are registered copies derived from the next state
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // Data path next values for the main and skid registers
   always_comb begin
      main_gen_d  = main_gen_q;
      main_prop_d = main_prop_q;
      skid_gen_d  = skid_gen_q;
      skid_prop_d = skid_prop_q;
      if (load_main_in) begin
         main_gen_d  = pg_gen;
         main_prop_d = pg_prop;
      end else if (load_main_skid) begin
         main_gen_d  = skid_gen_q;
         main_prop_d = skid_prop_q;
      end
      if (load_skid_in) begin
         skid_gen_d  = pg_gen;
         skid_prop_d = pg_prop;
      end
   end

   // State, handshake and data registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_gen_q  <= '0;
         main_prop_q <= '0;
         skid_gen_q  <= '0;
         skid_prop_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_gen_q  <= main_gen_d;
         main_prop_q <= main_prop_d;
         skid_gen_q  <= skid_gen_d;
         skid_prop_q <= skid_prop_d;
      end
   end

`ifdef PG_STAGE_CARRY_IN_EN
   logic main_cin_q, main_cin_d;
   logic skid_cin_q, skid_cin_d;

   // Carry-in travels with its operand pair through main and skid
   always_comb begin
      main_cin_d = main_cin_q;
      skid_cin_d = skid_cin_q;
      if (load_main_in) begin
         main_cin_d = in_cin;
      end else if (load_main_skid) begin
         main_cin_d = skid_cin_q;
      end
      if (load_skid_in) begin
         skid_cin_d = in_cin;
      end
   end

   // Carry-in registers share the data registers' reset behaviour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_cin_q <= 1'b0;
         skid_cin_q <= 1'b0;
      end else begin
         main_cin_q <= main_cin_d;
         skid_cin_q <= skid_cin_d;
      end
   end

   assign out_cin = main_cin_q;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_gen   = main_gen_q;
   assign out_prop  = main_prop_q;

endmodule : pg_generate_stage
`default_nettype wire

// File: tb/tb_pg_generate_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pg_generate_stage
//  Description : Self-checking bench for pg_generate_stage: directed vector
//                table, back-pressure, streaming, random handshake, reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pg_generate_stage;

   localparam int W = 16;
`ifdef PG_STAGE_CARRY_IN_EN
   localparam bit CIN_EN = 1'b1;
`else
   localparam bit CIN_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_gen;
   logic [W-1:0] out_prop;
   logic         act_cin;

   always #5 clk = ~clk;

   pg_generate_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef PG_STAGE_CARRY_IN_EN
      .in_cin    (in_cin),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gen   (out_gen),
`ifdef PG_STAGE_CARRY_IN_EN
      .out_cin   (act_cin),
`endif
      .out_prop  (out_prop)
   );
`ifndef PG_STAGE_CARRY_IN_EN
   assign act_cin = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] gen;
      logic [W-1:0] prop;
      logic         cin;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] gen;
      logic [W-1:0] prop;
   } vec_t;

   exp_t sb[$];
   int   pop_cyc[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   rec_pop = 1'b0;
   bit   rand_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: bit 0 generate is the majority of a0, b0 and cin
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t e;
      e.prop = a ^ b;
      e.gen  = a & b;
      e.gen[0] = (a[0] & b[0]) | (CIN_EN & ((a[0] & c) | (b[0] & c)));
      e.cin  = c & CIN_EN;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks
   // that a stalled output stays put
   logic         stall_prev = 1'b0;
   logic [W-1:0] prev_gen, prev_prop;
   logic         prev_cin;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            if (stall_prev) begin
               check("stall_valid", {31'd0, out_valid}, 32'd1);
               check("stall_gen", {16'd0, out_gen}, {16'd0, prev_gen});
               check("stall_prop", {16'd0, out_prop}, {16'd0, prev_prop});
`ifdef PG_STAGE_CARRY_IN_EN
               check("stall_cin", {31'd0, act_cin}, {31'd0, prev_cin});
`endif
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL extra_output: got gen=%h prop=%h, required none", out_gen, out_prop);
               end else begin
                  e = sb.pop_front();
                  check("sb_gen", {16'd0, out_gen}, {16'd0, e.gen});
                  check("sb_prop", {16'd0, out_prop}, {16'd0, e.prop});
`ifdef PG_STAGE_CARRY_IN_EN
                  check("sb_cin", {31'd0, act_cin}, {31'd0, e.cin});
`endif
                  if (rec_pop) pop_cyc.push_back(cyc);
               end
            end
            stall_prev = out_valid && !out_ready;
            prev_gen   = out_gen;
            prev_prop  = out_prop;
            prev_cin   = act_cin;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   // Offer one pair (called at a falling edge); returns at the falling edge
   // after the accepting rising edge, leaving in_valid high
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      for (int t = 0; t <= 50; t++) begin
         if (in_ready) begin
            sb.push_back(e);
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
      check("drain_empty", sb.size(), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;

      vecs.push_back('{16'h00FF, 16'h0F0F, 1'b0, 16'h000F, 16'h0FF0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000});
      vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000});
      vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF});
      vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, 16'h0000, 16'hFFFF});
      vecs.push_back('{16'hAAAA, 16'hAAAA, 1'b0, 16'hAAAA, 16'h0000});
      vecs.push_back('{16'h1234, 16'h00FF, 1'b0, 16'h0034, 16'h12CB});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h0000});
      vecs.push_back('{16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0001});
`ifdef PG_STAGE_CARRY_IN_EN
      vecs.push_back('{16'h0001, 16'h0000, 1'b1, 16'h0001, 16'h0001});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000});
      vecs.push_back('{16'h0001, 16'h0001, 1'b1, 16'h0001, 16'h0000});
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_gen", {16'd0, out_gen}, 32'd0);
      check("rst_out_prop", {16'd0, out_prop}, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single transfer: valid for exactly one cycle
      send(16'h00FF, 16'h0F0F, 1'b0, model(16'h00FF, 16'h0F0F, 1'b0));
      in_valid = 1'b0;
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_gen", {16'd0, out_gen}, 32'h000F);
      check("single_prop", {16'd0, out_prop}, 32'h0FF0);
      @(negedge clk);
      check("single_valid_drop", {31'd0, out_valid}, 32'd0);

      // Directed table with hand-computed expectations
      foreach (vecs[i]) begin
         exp_t e;
         e.gen  = vecs[i].gen;
         e.prop = vecs[i].prop;
         e.cin  = vecs[i].cin;
         send(vecs[i].a, vecs[i].b, vecs[i].cin, e);
      end
      in_valid = 1'b0;
      drain();

      // Back-pressure: two accepted, third ignored
      out_ready = 1'b0;
      @(negedge clk);
      send(16'h1111, 16'h0303, 1'b0, model(16'h1111, 16'h0303, 1'b0));
      check("bp_ready_one", {31'd0, in_ready}, 32'd1);
      send(16'hF0F0, 16'h3C3C, 1'b1, model(16'hF0F0, 16'h3C3C, 1'b1));
      check("bp_ready_full", {31'd0, in_ready}, 32'd0);
      in_a = 16'hDEAD;
      in_b = 16'hBEEF;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready_held", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      in_a = 16'h5A5A;
      out_ready = 1'b1;
      drain();
      repeat (2) @(negedge clk);
      check("bp_no_third", {31'd0, out_valid}, 32'd0);

      // Streaming: 100 back-to-back outputs
      pop_cyc.delete();
      rec_pop = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(1));
         send(ra, rb, rc, model(ra, rb, rc));
      end
      in_valid = 1'b0;
      drain();
      rec_pop = 1'b0;
      check("stream_count", pop_cyc.size(), 32'd100);
      if (pop_cyc.size() == 100)
         check("stream_no_bubble", pop_cyc[99] - pop_cyc[0], 32'd99);

      // Random valid/ready toggling
      rand_on = 1'b1;
      fork
         begin
            while (rand_on) begin
               @(negedge clk);
               if (rand_on) out_ready = 1'($urandom_range(1));
            end
         end
      join_none
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(1) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(1));
         send(ra, rb, rc, model(ra, rb, rc));
      end
      in_valid = 1'b0;
      rand_on = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      @(negedge clk);
      send(16'hFFFF, 16'h00FF, 1'b1, model(16'hFFFF, 16'h00FF, 1'b1));
      send(16'h0F0F, 16'hFFFF, 1'b1, model(16'h0F0F, 16'hFFFF, 1'b1));
      check("full_ready", {31'd0, in_ready}, 32'd0);
      mon_en = 1'b0;
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_out_gen", {16'd0, out_gen}, 32'd0);
      check("arst_out_prop", {16'd0, out_prop}, 32'd0);
`ifdef PG_STAGE_CARRY_IN_EN
      check("arst_out_cin", {31'd0, act_cin}, 32'd0);
`endif
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      mon_en = 1'b1;
      send(16'h0102, 16'h0306, 1'b0, model(16'h0102, 16'h0306, 1'b0));
      in_valid = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by 1ms, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pg_generate_stage
`default_nettype wire
